// File: rtl/l2_scrub_ctrl.sv
// l2_scrub_ctrl: background ECC scrubber walking an L2 address window with single reads
module l2_scrub_ctrl #(
    parameter int AddrWidth     = 48,
    parameter int WordBytes     = 8,
    parameter int IntervalWidth = 16,
    parameter int CntWidth      = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic [IntervalWidth-1:0] interval_i,
    input  logic [AddrWidth-1:0]     start_addr_i,
    input  logic [AddrWidth-1:0]     end_addr_i,
    input  logic                     busy_i,
    input  logic                     clr_i,
    output logic                     mem_req_o,
    output logic [AddrWidth-1:0]     mem_addr_o,
    input  logic                     mem_gnt_i,
    input  logic                     mem_rvalid_i,
    input  logic                     mem_ce_i,
    input  logic                     mem_ue_i,
    output logic [CntWidth-1:0]      ce_cnt_o,
    output logic [CntWidth-1:0]      ue_cnt_o,
    output logic [CntWidth-1:0]      pass_cnt_o,
    output logic                     pass_done_o,
    output logic                     active_o,
    output logic                     irq_o
);
    typedef enum logic [1:0] {IDLE, WAIT, REQ, RESP} state_e;
    localparam logic [AddrWidth-1:0] addr_mask = ~AddrWidth'(WordBytes - 1);
    localparam logic [AddrWidth-1:0] stride = AddrWidth'(WordBytes);
    state_e state;
    logic [AddrWidth-1:0] addr, win_end, start_al, end_al, end_eff;
    logic [IntervalWidth-1:0] cnt;
    logic rsp, wrap, ce_hit, ue_hit;
    always_comb begin
        start_al = start_addr_i & addr_mask;
        end_al = end_addr_i & addr_mask;
        end_eff = end_al < start_al ? start_al : end_al;
        rsp = state == RESP && mem_rvalid_i;
        wrap = rsp && addr == win_end;
        ce_hit = rsp && mem_ce_i;
        ue_hit = rsp && mem_ue_i;
    end
    assign mem_addr_o = addr;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            addr <= '0;
            win_end <= '0;
            cnt <= '0;
            mem_req_o <= 1'b0;
            active_o <= 1'b0;
            pass_done_o <= 1'b0;
        end else begin
            pass_done_o <= 1'b0;
            case (state)
                IDLE: if (en_i) begin
                    state <= WAIT;
                    active_o <= 1'b1;
                    addr <= start_al;
                    win_end <= end_eff;
                    cnt <= interval_i;
                end
                WAIT: if (!en_i) begin
                    state <= IDLE;
                    active_o <= 1'b0;
                end else if (cnt != '0) begin
                    cnt <= cnt - IntervalWidth'(1);
                end else if (!busy_i) begin
                    state <= REQ;
                    mem_req_o <= 1'b1;
                end
                REQ: if (mem_gnt_i) begin
                    state <= RESP;
                    mem_req_o <= 1'b0;
                end
                RESP: if (mem_rvalid_i) begin
                    state <= en_i ? WAIT : IDLE;
                    active_o <= en_i;
                    cnt <= interval_i;
                    pass_done_o <= wrap;
                    addr <= wrap ? start_al : addr + stride;
                    win_end <= wrap ? end_eff : win_end;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // clear beats a coincident event, including the irq set
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            ce_cnt_o <= '0;
            ue_cnt_o <= '0;
            pass_cnt_o <= '0;
            irq_o <= 1'b0;
        end else begin
            if (ce_hit && ce_cnt_o != '1) ce_cnt_o <= ce_cnt_o + CntWidth'(1);
            if (ue_hit && ue_cnt_o != '1) ue_cnt_o <= ue_cnt_o + CntWidth'(1);
            if (wrap && pass_cnt_o != '1) pass_cnt_o <= pass_cnt_o + CntWidth'(1);
            if (ue_hit) irq_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_l2_scrub_ctrl.sv
// tb_l2_scrub_ctrl: vector table, corner sequences and randomized model check of l2_scrub_ctrl
module tb_l2_scrub_ctrl;
    localparam int AW = 48;
    typedef struct {
        logic ce;
        logic ue;
        logic [AW-1:0] addr;
        int gap;
        int ce_c;
        int ue_c;
        int pass_c;
        logic irq;
        logic done;
    } vec_t;
    logic clk = 1'b0;
    logic rst_ni, en_i, busy_i, clr_i, mem_gnt_i, mem_rvalid_i, mem_ce_i, mem_ue_i;
    logic [15:0] interval_i;
    logic [AW-1:0] start_addr_i, end_addr_i, mem_addr_o;
    logic mem_req_o, pass_done_o, active_o, irq_o;
    logic [3:0] ce_cnt_o, ue_cnt_o, pass_cnt_o;
    int checks = 0, errors = 0, cyc = 0;
    vec_t tbl[5];
    always #5 clk = ~clk;
    l2_scrub_ctrl #(.AddrWidth(AW), .WordBytes(8), .IntervalWidth(16), .CntWidth(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .interval_i(interval_i),
        .start_addr_i(start_addr_i), .end_addr_i(end_addr_i), .busy_i(busy_i), .clr_i(clr_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_ce_i(mem_ce_i), .mem_ue_i(mem_ue_i),
        .ce_cnt_o(ce_cnt_o), .ue_cnt_o(ue_cnt_o), .pass_cnt_o(pass_cnt_o),
        .pass_done_o(pass_done_o), .active_o(active_o), .irq_o(irq_o)
    );
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic do_reset();
        rst_ni = 1'b0;
        en_i = 1'b0;
        busy_i = 1'b0;
        clr_i = 1'b0;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_ce_i = 1'b0;
        mem_ue_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask
    // waits for a request (busy held for the first b cycles), grants after gl cycles,
    // returns data rl cycles later; n = cycles spent waiting for the request
    task automatic do_read(input logic ce, input logic ue, input logic cl, input int gl,
                           input int rl, input int b, input int drop,
                           output logic [AW-1:0] a, output int n);
        n = 0;
        while (!mem_req_o && n < 200) begin
            busy_i = n < b;
            tick();
            n++;
            chk("done_quiet", 64'(pass_done_o), 64'd0);
        end
        busy_i = 1'b0;
        chk("req_seen", 64'(mem_req_o), 64'd1);
        a = mem_addr_o;
        for (int k = 0; k < gl; k++) begin
            if (k == drop) en_i = 1'b0;
            tick();
            chk("req_hold", 64'(mem_req_o), 64'd1);
            chk("addr_hold", 64'(mem_addr_o), 64'(a));
        end
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        chk("req_drop", 64'(mem_req_o), 64'd0);
        chk("active_resp", 64'(active_o), 64'd1);
        repeat (rl) tick();
        mem_rvalid_i = 1'b1;
        mem_ce_i = ce;
        mem_ue_i = ue;
        clr_i = cl;
        tick();
        mem_rvalid_i = 1'b0;
        mem_ce_i = 1'b0;
        mem_ue_i = 1'b0;
        clr_i = 1'b0;
    endtask
    function automatic logic [AW-1:0] align(input logic [AW-1:0] v);
        return v - (v % 8);
    endfunction
    function automatic logic [AW-1:0] rnd_addr();
        return AW'(48'h1000 + 48'($urandom_range(0, 12) * 8 + $urandom_range(0, 7)));
    endfunction
    function automatic int sat(input int v);
        return v >= 15 ? 15 : v + 1;
    endfunction
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end
    initial begin
        logic [AW-1:0] a, m_addr, m_end, s_al, e_al;
        int n, c0, prev_req, m_ce, m_ue, m_pass, m_int, b, exp_n, k;
        logic m_irq, wrap, ce, ue, cl, first;
        interval_i = 16'd0;
        start_addr_i = '0;
        end_addr_i = '0;
        busy_i = 1'b0;
        clr_i = 1'b0;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_ce_i = 1'b0;
        mem_ue_i = 1'b0;
        rst_ni = 1'b0;
        en_i = 1'b1;
        tick();
        tick();
        chk("rst_req", 64'(mem_req_o), 64'd0);
        chk("rst_addr", 64'(mem_addr_o), 64'd0);
        chk("rst_active", 64'(active_o), 64'd0);
        chk("rst_cnts", 64'({ce_cnt_o, ue_cnt_o, pass_cnt_o}), 64'd0);
        chk("rst_irq_done", 64'({irq_o, pass_done_o}), 64'd0);
        // basic pass with error injection: interval 2, zero grant/read latency
        tbl[0] = '{1'b0, 1'b0, 48'h100, 4, 0, 0, 0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 48'h108, 3, 1, 0, 0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 48'h110, 3, 1, 0, 0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 48'h118, 3, 2, 1, 1, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 48'h100, 3, 2, 1, 1, 1'b1, 1'b0};
        do_reset();
        start_addr_i = 48'h100;
        end_addr_i = 48'h11f;
        interval_i = 16'd2;
        en_i = 1'b1;
        prev_req = 0;
        for (int i = 0; i < 5; i++) begin
            c0 = cyc;
            do_read(tbl[i].ce, tbl[i].ue, 1'b0, 0, 0, 0, -1, a, n);
            chk("tbl_addr", 64'(a), 64'(tbl[i].addr));
            chk("tbl_gap", 64'(n), 64'(tbl[i].gap));
            if (i > 0) chk("tbl_req_period", 64'(c0 + n - prev_req), 64'd5);
            prev_req = c0 + n;
            chk("tbl_ce", 64'(ce_cnt_o), 64'(tbl[i].ce_c));
            chk("tbl_ue", 64'(ue_cnt_o), 64'(tbl[i].ue_c));
            chk("tbl_pass", 64'(pass_cnt_o), 64'(tbl[i].pass_c));
            chk("tbl_irq", 64'(irq_o), 64'(tbl[i].irq));
            chk("tbl_done", 64'(pass_done_o), 64'(tbl[i].done));
        end
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("clr_cnts", 64'({ce_cnt_o, ue_cnt_o, pass_cnt_o}), 64'd0);
        chk("clr_irq", 64'(irq_o), 64'd0);
        // busy deferral
        do_reset();
        start_addr_i = 48'h200;
        end_addr_i = 48'h210;
        interval_i = 16'd0;
        busy_i = 1'b1;
        en_i = 1'b1;
        for (int i = 0; i < 22; i++) begin
            tick();
            chk("busy_no_req", 64'(mem_req_o), 64'd0);
        end
        chk("busy_active", 64'(active_o), 64'd1);
        busy_i = 1'b0;
        tick();
        chk("busy_req_after", 64'(mem_req_o), 64'd1);
        chk("busy_addr", 64'(mem_addr_o), 64'h200);
        do_read(1'b0, 1'b0, 1'b0, 0, 0, 0, -1, a, n);
        chk("busy_n0", 64'(n), 64'd0);
        do_read(1'b0, 1'b0, 1'b0, 0, 0, 0, -1, a, n);
        chk("busy_next_addr", 64'(a), 64'h208);
        chk("busy_next_gap", 64'(n), 64'd1);
        // stalled grant with enable dropped mid-request
        do_reset();
        start_addr_i = 48'h300;
        end_addr_i = 48'h318;
        interval_i = 16'd1;
        en_i = 1'b1;
        do_read(1'b1, 1'b0, 1'b0, 10, 1, 0, 3, a, n);
        chk("stall_addr", 64'(a), 64'h300);
        chk("stall_ce", 64'(ce_cnt_o), 64'd1);
        chk("stall_idle", 64'(active_o), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_no_req", 64'({mem_req_o, active_o}), 64'd0);
        end
        // saturation and clear racing an event
        do_reset();
        start_addr_i = 48'h400;
        end_addr_i = 48'h438;
        interval_i = 16'd0;
        en_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            do_read(1'b1, 1'b0, 1'b0, 0, 0, 0, -1, a, n);
            chk("sat_ce", 64'(ce_cnt_o), 64'(i < 15 ? i + 1 : 15));
        end
        do_read(1'b1, 1'b0, 1'b1, 0, 0, 0, -1, a, n);
        chk("sat_clr_race", 64'(ce_cnt_o), 64'd0);
        // degenerate window then reset while a read is outstanding
        do_reset();
        start_addr_i = 48'h100;
        end_addr_i = 48'h0f8;
        interval_i = 16'd0;
        en_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_read(1'b0, i == 2, 1'b0, 0, 0, 0, -1, a, n);
            chk("degen_addr", 64'(a), 64'h100);
            chk("degen_done", 64'(pass_done_o), 64'd1);
            chk("degen_pass", 64'(pass_cnt_o), 64'(i + 1));
        end
        chk("degen_irq", 64'(irq_o), 64'd1);
        k = 0;
        while (!mem_req_o && k < 50) begin
            tick();
            k++;
        end
        chk("rr_req_seen", 64'(mem_req_o), 64'd1);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        rst_ni = 1'b0;
        tick();
        chk("rr_req", 64'(mem_req_o), 64'd0);
        chk("rr_active", 64'(active_o), 64'd0);
        chk("rr_addr", 64'(mem_addr_o), 64'd0);
        chk("rr_cnts", 64'({ce_cnt_o, ue_cnt_o, pass_cnt_o}), 64'd0);
        chk("rr_irq_done", 64'({irq_o, pass_done_o}), 64'd0);
        rst_ni = 1'b1;
        en_i = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_ce_i = 1'b1;
        mem_ue_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b0;
        mem_ce_i = 1'b0;
        mem_ue_i = 1'b0;
        chk("late_rvalid_cnts", 64'({ce_cnt_o, ue_cnt_o, pass_cnt_o}), 64'd0);
        chk("late_rvalid_irq", 64'(irq_o), 64'd0);
        // randomized traffic against a transaction-level model
        do_reset();
        start_addr_i = rnd_addr();
        end_addr_i = rnd_addr();
        interval_i = 16'($urandom_range(0, 3));
        s_al = align(start_addr_i);
        e_al = align(end_addr_i);
        m_addr = s_al;
        m_end = e_al < s_al ? s_al : e_al;
        m_int = int'(interval_i);
        {m_ce, m_ue, m_pass} = '0;
        m_irq = 1'b0;
        first = 1'b1;
        en_i = 1'b1;
        for (int t = 0; t < 80; t++) begin
            ce = 1'($urandom_range(0, 1));
            ue = $urandom_range(0, 3) == 0;
            cl = $urandom_range(0, 9) == 0;
            b = first ? 0 : ($urandom_range(0, 2) == 0 ? int'($urandom_range(1, 6)) : 0);
            exp_n = first ? m_int + 2 : (m_int > b ? m_int : b) + 1;
            do_read(ce, ue, cl, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), b, -1, a, n);
            chk("rnd_addr", 64'(a), 64'(m_addr));
            chk("rnd_gap", 64'(n), 64'(exp_n));
            wrap = m_addr == m_end;
            if (wrap) begin
                s_al = align(start_addr_i);
                e_al = align(end_addr_i);
                m_addr = s_al;
                m_end = e_al < s_al ? s_al : e_al;
            end else begin
                m_addr = m_addr + 8;
            end
            if (cl) begin
                {m_ce, m_ue, m_pass} = '0;
                m_irq = 1'b0;
            end else begin
                if (ce) m_ce = sat(m_ce);
                if (ue) m_ue = sat(m_ue);
                if (ue) m_irq = 1'b1;
                if (wrap) m_pass = sat(m_pass);
            end
            chk("rnd_ce", 64'(ce_cnt_o), 64'(m_ce));
            chk("rnd_ue", 64'(ue_cnt_o), 64'(m_ue));
            chk("rnd_pass", 64'(pass_cnt_o), 64'(m_pass));
            chk("rnd_irq", 64'(irq_o), 64'(m_irq));
            chk("rnd_done", 64'(pass_done_o), 64'(wrap));
            m_int = int'(interval_i);
            first = 1'b0;
            if ($urandom_range(0, 3) == 0) interval_i = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                start_addr_i = rnd_addr();
                end_addr_i = rnd_addr();
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
